rs_issue_scheduler: RTL and testbench

- Issue scheduler for the 16-entry reservation station.
- Tracks entry occupancy, operand readiness and relative age. Allocates up to 2 entries per cycle from dispatch and applies wakeup broadcasts from the complete stage.
- Each cycle selects the oldest ready entry per functional unit: two ALUs and one MEM port.
- Sits between dispatch/ROB allocation and the FU issue ports. The RS payload RAM is written at the disp_entry indices this block returns.

---
 rtl/rs_pkg.sv | 65 ++++++
 rtl/rs_issue_scheduler_if.sv | 34 +++
 rtl/rs_age_select.sv | 28 ++
 rtl/rs_issue_scheduler.sv | 166 ++++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_pkg.sv
// Shared constants, entry/issue record types and small helpers for the
// reservation-station issue scheduler.
package rs_pkg;

   localparam int NUM_ENTRIES = 16;
   localparam int IDX_W       = 4;
   localparam int TAG_W       = 6;
   localparam int ROB_W       = 4;
   localparam int NUM_DISP    = 2;
   localparam int NUM_WAKE    = 2;
   localparam int NUM_FU      = 3;
   localparam int CNT_W       = IDX_W + 1;

   typedef enum logic {
      FU_ALU = 1'b0,
      FU_MEM = 1'b1
   } fu_class_e;

   typedef struct packed {
      logic             valid;
      fu_class_e        fu;
      logic [TAG_W-1:0] src1tag;
      logic [TAG_W-1:0] src2tag;
      logic             src1rdy;
      logic             src2rdy;
      logic [ROB_W-1:0] rob;
   } rsSchedEntry;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] entry;
      logic [ROB_W-1:0] rob;
   } rsIssueStruct;

   // Tag 0 is hardwired ready; any valid broadcast of the tag also readies it.
   function automatic logic src_ready(
      input logic                           rdy,
      input logic [TAG_W-1:0]               tag,
      input logic [NUM_WAKE-1:0]            wake_valid,
      input logic [NUM_WAKE-1:0][TAG_W-1:0] wake_tag
   );
      logic hit;
      hit = rdy | (tag == {TAG_W{1'b0}});
      for (int w = 0; w < NUM_WAKE; w++) begin
         hit = hit | (wake_valid[w] & (wake_tag[w] == tag));
      end
      return hit;
   endfunction

   function automatic logic [NUM_ENTRIES-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_ENTRIES-1:0] one;
      one = {{(NUM_ENTRIES-1){1'b0}}, 1'b1};
      return one << idx;
   endfunction

   function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_ENTRIES-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = {IDX_W{1'b0}};
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         idx = vec[i] ? IDX_W'(i) : idx;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rs_issue_scheduler_if.sv
// Dispatch, wakeup and issue bundle between the pipeline and the RS scheduler.
interface rs_issue_scheduler_if;
   import rs_pkg::*;

   logic [NUM_DISP-1:0]            disp_valid;
   logic [NUM_DISP-1:0]            disp_fu;
   logic [NUM_DISP-1:0][TAG_W-1:0] disp_src1_tag;
   logic [NUM_DISP-1:0][TAG_W-1:0] disp_src2_tag;
   logic [NUM_DISP-1:0]            disp_src1_rdy;
   logic [NUM_DISP-1:0]            disp_src2_rdy;
   logic [NUM_DISP-1:0][ROB_W-1:0] disp_rob;
   logic                           disp_stall;
   logic [NUM_DISP-1:0][IDX_W-1:0] disp_entry;
   logic [NUM_WAKE-1:0]            wake_valid;
   logic [NUM_WAKE-1:0][TAG_W-1:0] wake_tag;
   logic [NUM_FU-1:0]              fu_rdy;
   logic [NUM_FU-1:0]              issue_valid;
   logic [NUM_FU-1:0][IDX_W-1:0]   issue_entry;
   logic [NUM_FU-1:0][ROB_W-1:0]   issue_rob;
   logic [CNT_W-1:0]               free_count;

   modport master (
      output disp_valid, disp_fu, disp_src1_tag, disp_src2_tag,
             disp_src1_rdy, disp_src2_rdy, disp_rob, wake_valid, wake_tag, fu_rdy,
      input  disp_stall, disp_entry, issue_valid, issue_entry, issue_rob, free_count
   );

   modport slave (
      input  disp_valid, disp_fu, disp_src1_tag, disp_src2_tag,
             disp_src1_rdy, disp_src2_rdy, disp_rob, wake_valid, wake_tag, fu_rdy,
      output disp_stall, disp_entry, issue_valid, issue_entry, issue_rob, free_count
   );

endinterface

// File: rtl/rs_age_select.sv
// Combinational oldest-first picker: grants the requesting entry that no other
// requesting entry is older than (age[j][i]=1 means j is older than i).
module rs_age_select
   import rs_pkg::*;
(
   input  logic [NUM_ENTRIES-1:0]                  req,
   input  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age,
   output logic [IDX_W-1:0]                        grant_idx,
   output logic                                    grant_valid
);

   logic [NUM_ENTRIES-1:0] oldest_s;

   always_comb begin
      logic blocked;
      oldest_s = {NUM_ENTRIES{1'b0}};
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         blocked = 1'b0;
         for (int j = 0; j < NUM_ENTRIES; j++) begin
            blocked = blocked | (req[j] & age[j][i] & (j != i));
         end
         oldest_s[i] = req[i] & ~blocked;
      end
      grant_valid = |oldest_s;
      grant_idx   = lowest_set(oldest_s);
   end

endmodule

// File: rtl/rs_issue_scheduler.sv
// 16-entry reservation-station scheduler: two-wide allocation, tag wakeup,
// age-ordered select for ALU0/ALU1/MEM with a registered issue stage.
module rs_issue_scheduler
   import rs_pkg::*;
(
   input logic                clk,
   input logic                reset,
   input logic                flush,
   rs_issue_scheduler_if.slave bus
);

   rsSchedEntry [NUM_ENTRIES-1:0]                  entry_r, entry_n_s;
   logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0]        age_r, age_n_s;
   rsIssueStruct [NUM_FU-1:0]                      issue_r, issue_n_s;
   logic [CNT_W-1:0]                               free_count_r, free_count_n_s;

   logic [NUM_ENTRIES-1:0]         valid_s, free_s, alu_elig_s, mem_elig_s, issued_s;
   logic [NUM_ENTRIES-1:0]         new0_s, new1_s, new_any_s;
   logic [NUM_ENTRIES-1:0]         req_alu0_s, req_alu1_s, req_mem_s;
   logic [IDX_W-1:0]               alu0_idx_s, alu1_idx_s, mem_idx_s;
   logic                           alu0_vld_s, alu1_vld_s, mem_vld_s;
   logic [NUM_FU-1:0][IDX_W-1:0]   grant_idx_s;
   logic [NUM_FU-1:0]              grant_valid_s;
   logic [IDX_W-1:0]               first_idx_s, second_idx_s;
   logic [NUM_DISP-1:0][IDX_W-1:0] disp_idx_s;
   logic [NUM_DISP-1:0]            alloc_s;
   rsSchedEntry [NUM_DISP-1:0]     new_s;
   logic                           disp_stall_s;
   logic [CNT_W-1:0]               issued_cnt_s, alloc_cnt_s;

   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         valid_s[i]    = entry_r[i].valid;
         alu_elig_s[i] = entry_r[i].valid & entry_r[i].src1rdy & entry_r[i].src2rdy
                         & (entry_r[i].fu == FU_ALU);
         mem_elig_s[i] = entry_r[i].valid & entry_r[i].src1rdy & entry_r[i].src2rdy
                         & (entry_r[i].fu == FU_MEM);
      end
      free_s = ~valid_s;
   end

   // Slot0 gets the lowest free entry, slot1 the next; a stalled or flushed cycle writes nothing.
   always_comb begin
      disp_stall_s  = (free_count_r < CNT_W'(2));
      first_idx_s   = lowest_set(free_s);
      second_idx_s  = lowest_set(free_s & ~idx_onehot(first_idx_s));
      disp_idx_s[0] = first_idx_s;
      disp_idx_s[1] = second_idx_s;
      for (int k = 0; k < NUM_DISP; k++) begin
         alloc_s[k]       = bus.disp_valid[k] & ~disp_stall_s & ~flush;
         new_s[k].valid   = 1'b1;
         new_s[k].fu      = fu_class_e'(bus.disp_fu[k]);
         new_s[k].src1tag = bus.disp_src1_tag[k];
         new_s[k].src2tag = bus.disp_src2_tag[k];
         new_s[k].src1rdy = src_ready(bus.disp_src1_rdy[k], bus.disp_src1_tag[k],
                                      bus.wake_valid, bus.wake_tag);
         new_s[k].src2rdy = src_ready(bus.disp_src2_rdy[k], bus.disp_src2_tag[k],
                                      bus.wake_valid, bus.wake_tag);
         new_s[k].rob     = bus.disp_rob[k];
      end
      new0_s      = idx_onehot(first_idx_s) & {NUM_ENTRIES{alloc_s[0]}};
      new1_s      = idx_onehot(second_idx_s) & {NUM_ENTRIES{alloc_s[1]}};
      new_any_s   = new0_s | new1_s;
      alloc_cnt_s = CNT_W'(alloc_s[0]) + CNT_W'(alloc_s[1]);
   end

   assign req_alu0_s = alu_elig_s & {NUM_ENTRIES{bus.fu_rdy[0]}};
   assign req_mem_s  = mem_elig_s & {NUM_ENTRIES{bus.fu_rdy[2]}};
   // ALU1 sees the ALU pool minus whatever ALU0 took this cycle.
   assign req_alu1_s = alu_elig_s & ~(idx_onehot(alu0_idx_s) & {NUM_ENTRIES{alu0_vld_s}})
                       & {NUM_ENTRIES{bus.fu_rdy[1]}};

   rs_age_select u_sel_alu0 (
      .req         (req_alu0_s),
      .age         (age_r),
      .grant_idx   (alu0_idx_s),
      .grant_valid (alu0_vld_s)
   );

   rs_age_select u_sel_alu1 (
      .req         (req_alu1_s),
      .age         (age_r),
      .grant_idx   (alu1_idx_s),
      .grant_valid (alu1_vld_s)
   );

   rs_age_select u_sel_mem (
      .req         (req_mem_s),
      .age         (age_r),
      .grant_idx   (mem_idx_s),
      .grant_valid (mem_vld_s)
   );

   always_comb begin
      grant_idx_s   = {mem_idx_s, alu1_idx_s, alu0_idx_s};
      grant_valid_s = {mem_vld_s, alu1_vld_s, alu0_vld_s};
      issued_s      = {NUM_ENTRIES{1'b0}};
      issued_cnt_s  = {CNT_W{1'b0}};
      for (int f = 0; f < NUM_FU; f++) begin
         issued_s           = issued_s | (idx_onehot(grant_idx_s[f]) & {NUM_ENTRIES{grant_valid_s[f]}});
         issued_cnt_s       = issued_cnt_s + CNT_W'(grant_valid_s[f]);
         issue_n_s[f].valid = grant_valid_s[f];
         issue_n_s[f].entry = grant_valid_s[f] ? grant_idx_s[f] : {IDX_W{1'b0}};
         issue_n_s[f].rob   = grant_valid_s[f] ? entry_r[grant_idx_s[f]].rob : {ROB_W{1'b0}};
      end
      free_count_n_s = free_count_r + issued_cnt_s - alloc_cnt_s;
   end

   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (new0_s[i]) begin
            entry_n_s[i] = new_s[0];
         end else if (new1_s[i]) begin
            entry_n_s[i] = new_s[1];
         end else begin
            entry_n_s[i]         = entry_r[i];
            entry_n_s[i].valid   = entry_r[i].valid & ~issued_s[i];
            entry_n_s[i].src1rdy = src_ready(entry_r[i].src1rdy, entry_r[i].src1tag,
                                             bus.wake_valid, bus.wake_tag);
            entry_n_s[i].src2rdy = src_ready(entry_r[i].src2rdy, entry_r[i].src2tag,
                                             bus.wake_valid, bus.wake_tag);
         end
      end
   end

   // A new row is cleared (slot0 still beats a same-cycle slot1); its column marks every live entry older.
   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         for (int j = 0; j < NUM_ENTRIES; j++) begin
            if (new_any_s[i]) begin
               age_n_s[i][j] = new0_s[i] & new1_s[j];
            end else if (new_any_s[j]) begin
               age_n_s[i][j] = valid_s[i];
            end else begin
               age_n_s[i][j] = age_r[i][j];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         entry_r      <= '0;
         age_r        <= '0;
         issue_r      <= '0;
         free_count_r <= CNT_W'(NUM_ENTRIES);
      end else begin
         entry_r      <= entry_n_s;
         age_r        <= age_n_s;
         issue_r      <= issue_n_s;
         free_count_r <= free_count_n_s;
      end
   end

   always_comb begin
      bus.disp_stall = disp_stall_s;
      bus.disp_entry = disp_idx_s;
      bus.free_count = free_count_r;
      for (int f = 0; f < NUM_FU; f++) begin
         bus.issue_valid[f] = issue_r[f].valid;
         bus.issue_entry[f] = issue_r[f].entry;
         bus.issue_rob[f]   = issue_r[f].rob;
      end
   end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler with hand-computed expectations.
module tb_rs_issue_scheduler;
   import rs_pkg::*;

   logic clk;
   logic reset;
   logic flush;
   int   n_checks;
   int   n_bad;

   rs_issue_scheduler_if bus ();

   rs_issue_scheduler dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.disp_valid    = 2'b00;
      bus.disp_fu       = 2'b00;
      bus.disp_src1_tag = '0;
      bus.disp_src2_tag = '0;
      bus.disp_src1_rdy = 2'b00;
      bus.disp_src2_rdy = 2'b00;
      bus.disp_rob      = '0;
      bus.wake_valid    = 2'b00;
      bus.wake_tag      = '0;
   endtask

   task automatic set_disp(input int s, input logic fu, input logic [5:0] t1, input logic [5:0] t2,
                           input logic r1, input logic r2, input logic [3:0] rob);
      bus.disp_valid[s]    = 1'b1;
      bus.disp_fu[s]       = fu;
      bus.disp_src1_tag[s] = t1;
      bus.disp_src2_tag[s] = t2;
      bus.disp_src1_rdy[s] = r1;
      bus.disp_src2_rdy[s] = r2;
      bus.disp_rob[s]      = rob;
   endtask

   initial begin
      n_checks = 0;
      n_bad    = 0;
      reset    = 1'b1;
      flush    = 1'b0;
      clear_in();
      bus.fu_rdy = 3'b000;
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Reset / idle
      check_eq("rst_free",  32'(bus.free_count),     32'd16);
      check_eq("rst_stall", 32'(bus.disp_stall),     32'd0);
      check_eq("rst_issue", 32'(bus.issue_valid),    32'd0);
      check_eq("rst_e0",    32'(bus.disp_entry[0]),  32'd0);
      check_eq("rst_e1",    32'(bus.disp_entry[1]),  32'd1);

      // Two ready ALU ops issue together on ALU0/ALU1
      bus.fu_rdy = 3'b111;
      set_disp(0, 1'b0, 6'd5, 6'd6, 1'b1, 1'b1, 4'd3);
      set_disp(1, 1'b0, 6'd7, 6'd8, 1'b1, 1'b1, 4'd4);
      tick();
      clear_in();
      check_eq("pair_free",  32'(bus.free_count),    32'd14);
      check_eq("pair_de0",   32'(bus.disp_entry[0]), 32'd2);
      check_eq("pair_de1",   32'(bus.disp_entry[1]), 32'd3);
      check_eq("pair_iv0",   32'(bus.issue_valid),   32'd0);
      tick();
      check_eq("pair_iv",    32'(bus.issue_valid),    32'd3);
      check_eq("pair_ie0",   32'(bus.issue_entry[0]), 32'd0);
      check_eq("pair_ie1",   32'(bus.issue_entry[1]), 32'd1);
      check_eq("pair_ir0",   32'(bus.issue_rob[0]),   32'd3);
      check_eq("pair_ir1",   32'(bus.issue_rob[1]),   32'd4);
      check_eq("pair_free2", 32'(bus.free_count),     32'd16);
      tick();
      check_eq("pair_pulse", 32'(bus.issue_valid),    32'd0);

      // Wakeup of a waiting entry; src2 uses the always-ready tag 0
      set_disp(0, 1'b0, 6'd9, 6'd0, 1'b0, 1'b0, 4'd5);
      tick();
      clear_in();
      check_eq("wk_free",   32'(bus.free_count),  32'd15);
      tick();
      check_eq("wk_wait",   32'(bus.issue_valid), 32'd0);
      bus.wake_valid  = 2'b01;
      bus.wake_tag[0] = 6'd9;
      tick();
      clear_in();
      check_eq("wk_nobyp",  32'(bus.issue_valid),    32'd0);
      tick();
      check_eq("wk_iv",     32'(bus.issue_valid),    32'd1);
      check_eq("wk_ie",     32'(bus.issue_entry[0]), 32'd0);
      check_eq("wk_ir",     32'(bus.issue_rob[0]),   32'd5);
      tick();
      check_eq("wk_pulse",  32'(bus.issue_valid),    32'd0);
      check_eq("wk_free2",  32'(bus.free_count),     32'd16);

      // Dispatch/wake bypass
      set_disp(0, 1'b0, 6'd9, 6'd10, 1'b0, 1'b1, 4'd6);
      bus.wake_valid  = 2'b10;
      bus.wake_tag[1] = 6'd9;
      tick();
      clear_in();
      check_eq("byp_iv0", 32'(bus.issue_valid),  32'd0);
      tick();
      check_eq("byp_iv",  32'(bus.issue_valid),  32'd1);
      check_eq("byp_ir",  32'(bus.issue_rob[0]), 32'd6);
      tick();
      check_eq("byp_free", 32'(bus.free_count),  32'd16);

      // Fill with unready MEM ops
      for (int c = 0; c < 8; c++) begin
         set_disp(0, 1'b1, 6'd20, 6'd0, 1'b0, 1'b0, 4'(2 * c));
         set_disp(1, 1'b1, 6'd20, 6'd0, 1'b0, 1'b0, 4'(2 * c + 1));
         tick();
      end
      clear_in();
      check_eq("full_free",  32'(bus.free_count), 32'd0);
      check_eq("full_stall", 32'(bus.disp_stall), 32'd1);
      set_disp(0, 1'b0, 6'd1, 6'd2, 1'b1, 1'b1, 4'd9);
      set_disp(1, 1'b0, 6'd3, 6'd4, 1'b1, 1'b1, 4'd10);
      tick();
      clear_in();
      check_eq("full_ign_free", 32'(bus.free_count),  32'd0);
      tick();
      check_eq("full_ign_iv",   32'(bus.issue_valid), 32'd0);
      bus.fu_rdy      = 3'b100;
      bus.wake_valid  = 2'b01;
      bus.wake_tag[0] = 6'd20;
      tick();
      clear_in();
      check_eq("mem_nobyp", 32'(bus.issue_valid), 32'd0);
      for (int k = 0; k < 16; k++) begin
         tick();
         check_eq("mem_iv",    32'(bus.issue_valid),    32'd4);
         check_eq("mem_ie",    32'(bus.issue_entry[2]), 32'(k));
         check_eq("mem_ir",    32'(bus.issue_rob[2]),   32'(k));
         check_eq("mem_free",  32'(bus.free_count),     32'(k + 1));
         check_eq("mem_stall", 32'(bus.disp_stall),     (k < 1) ? 32'd1 : 32'd0);
      end
      tick();
      check_eq("mem_done", 32'(bus.issue_valid), 32'd0);

      // Age beats index: entry 3 older than reallocated entry 1
      bus.fu_rdy = 3'b011;
      set_disp(0, 1'b0, 6'd30, 6'd0, 1'b0, 1'b0, 4'd1);
      set_disp(1, 1'b0, 6'd30, 6'd0, 1'b0, 1'b0, 4'd2);
      tick();
      set_disp(0, 1'b0, 6'd31, 6'd0, 1'b0, 1'b0, 4'd3);
      set_disp(1, 1'b0, 6'd41, 6'd0, 1'b0, 1'b0, 4'd4);
      tick();
      clear_in();
      bus.wake_valid  = 2'b01;
      bus.wake_tag[0] = 6'd30;
      tick();
      clear_in();
      check_eq("age_nobyp", 32'(bus.issue_valid), 32'd0);
      tick();
      check_eq("age_iv01",  32'(bus.issue_valid),    32'd3);
      check_eq("age_ie0",   32'(bus.issue_entry[0]), 32'd0);
      check_eq("age_ie1",   32'(bus.issue_entry[1]), 32'd1);
      check_eq("age_free",  32'(bus.free_count),     32'd14);
      check_eq("age_de0",   32'(bus.disp_entry[0]),  32'd0);
      check_eq("age_de1",   32'(bus.disp_entry[1]),  32'd1);
      set_disp(0, 1'b0, 6'd33, 6'd0, 1'b0, 1'b0, 4'd5);
      set_disp(1, 1'b0, 6'd42, 6'd0, 1'b0, 1'b0, 4'd6);
      tick();
      clear_in();
      check_eq("age_free2", 32'(bus.free_count),  32'd12);
      bus.fu_rdy      = 3'b010;
      bus.wake_valid  = 2'b11;
      bus.wake_tag[0] = 6'd41;
      bus.wake_tag[1] = 6'd42;
      tick();
      clear_in();
      check_eq("age_nobyp2", 32'(bus.issue_valid),    32'd0);
      tick();
      check_eq("age_first",  32'(bus.issue_valid),    32'd2);
      check_eq("age_fe",     32'(bus.issue_entry[1]), 32'd3);
      check_eq("age_fr",     32'(bus.issue_rob[1]),   32'd4);
      tick();
      check_eq("age_second", 32'(bus.issue_valid),    32'd2);
      check_eq("age_se",     32'(bus.issue_entry[1]), 32'd1);
      check_eq("age_sr",     32'(bus.issue_rob[1]),   32'd6);
      tick();
      check_eq("age_done",   32'(bus.issue_valid),    32'd0);
      check_eq("age_free3",  32'(bus.free_count),     32'd14);

      // Flush with 10 valid entries and one pending select
      bus.fu_rdy = 3'b111;
      for (int c = 0; c < 4; c++) begin
         set_disp(0, 1'b0, 6'd50, 6'd0, 1'b0, 1'b0, 4'(7 + c));
         if (c == 3) begin
            set_disp(1, 1'b0, 6'd1, 6'd2, 1'b1, 1'b1, 4'd12);
         end else begin
            set_disp(1, 1'b0, 6'd50, 6'd0, 1'b0, 1'b0, 4'd11);
         end
         tick();
      end
      clear_in();
      check_eq("fl_pre_free", 32'(bus.free_count),  32'd6);
      check_eq("fl_pre_iv",   32'(bus.issue_valid), 32'd0);
      flush = 1'b1;
      set_disp(0, 1'b0, 6'd1, 6'd2, 1'b1, 1'b1, 4'd13);
      bus.wake_valid  = 2'b01;
      bus.wake_tag[0] = 6'd50;
      tick();
      flush = 1'b0;
      clear_in();
      check_eq("fl_iv",    32'(bus.issue_valid),   32'd0);
      check_eq("fl_free",  32'(bus.free_count),    32'd16);
      check_eq("fl_de0",   32'(bus.disp_entry[0]), 32'd0);
      check_eq("fl_de1",   32'(bus.disp_entry[1]), 32'd1);
      tick();
      check_eq("fl_iv2",   32'(bus.issue_valid),   32'd0);
      check_eq("fl_free2", 32'(bus.free_count),    32'd16);

      // Reset during dispatch drops the dispatched ops
      set_disp(0, 1'b0, 6'd1, 6'd2, 1'b1, 1'b1, 4'd14);
      set_disp(1, 1'b1, 6'd3, 6'd4, 1'b1, 1'b1, 4'd15);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clear_in();
      check_eq("rd_free",  32'(bus.free_count),  32'd16);
      check_eq("rd_iv",    32'(bus.issue_valid), 32'd0);
      tick();
      check_eq("rd_iv2",   32'(bus.issue_valid), 32'd0);
      check_eq("rd_free2", 32'(bus.free_count),  32'd16);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
